// File: rtl/onehot_select_pkg.sv
// Shared types and decode helper for the one-hot select generator family.
package onehot_select_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    HOLD  = 2'd1,
    SCAN  = 2'd2
  } sel_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest decode supported; callers size-cast the result down to their line count.
  localparam int ONEHOT_MAX = 256;

  function automatic logic [ONEHOT_MAX-1:0] onehot_dec(input int unsigned idx, input int unsigned n);
    logic [ONEHOT_MAX-1:0] v;
    for (int unsigned i = 0; i < ONEHOT_MAX; i++) v[i] = (i == idx) && (i < n);
    return v;
  endfunction

endpackage

// File: rtl/onehot_select_gen_dwell.sv
// Dwell counter: counts 0..DWELL-1 while enabled, flags the last count.
module dwell_counter
  import onehot_select_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cen,
  output logic tc
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cen) cnt <= tc ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/onehot_select_gen.sv
// Registered binary-to-one-hot select with host load, auto-scan, range check
// and step/wrap/err status pulses.
module onehot_select_gen
  import onehot_select_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 2**SEL_W,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               load_valid,
  input  logic [SEL_W-1:0]   load_idx,
  output logic [NUM_OUT-1:0] dout,
  output logic [SEL_W-1:0]   idx,
  output logic               step,
  output logic               wrap,
  output logic               err
);

  localparam logic [SEL_W:0]     N_W      = (SEL_W + 1)'(NUM_OUT);
  localparam logic [SEL_W-1:0]   LAST     = SEL_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] INACTIVE = {NUM_OUT{ACTIVE_LOW}};

  sel_state_t         state, state_nx;
  logic               load_ok, load_bad;
  logic               cnt_clr, cnt_en, tc, advance, at_last;
  logic [SEL_W-1:0]   idx_nx;
  logic [NUM_OUT-1:0] dec;

  always_comb begin
    state_nx = BLANK;
    if (en) state_nx = (mode == MODE_SCAN) ? SCAN : HOLD;
  end

  assign load_ok  = load_valid && ({1'b0, load_idx} < N_W);
  assign load_bad = load_valid && !load_ok;

  // Any load (good or bad) pre-empts the dwell logic; a rejected one freezes it.
  assign cnt_clr = load_ok ||
                   (!load_valid && state_nx != BLANK && (state_nx != state || state_nx == HOLD));
  assign cnt_en  = !load_valid && state == SCAN && state_nx == SCAN;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .cen (cnt_en),
    .tc  (tc)
  );

  assign advance = cnt_en && tc;
  assign at_last = (idx == LAST);

  always_comb begin
    idx_nx = idx;
    if (load_ok)      idx_nx = load_idx;
    else if (advance) idx_nx = at_last ? '0 : idx + 1'b1;
  end

  assign dec = NUM_OUT'(onehot_dec(32'(idx_nx), 32'(NUM_OUT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      idx   <= '0;
      dout  <= INACTIVE;
      step  <= 1'b0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      dout  <= ((state_nx != BLANK) ? dec : '0) ^ INACTIVE;
      step  <= advance;
      wrap  <= advance && at_last;
      err   <= load_bad;
    end
  end

endmodule
